// File: rtl/axis_packet_merge_pkg.sv
// Shared types and constants for the two-input packet-atomic AXI-Stream merger.
// Holds the arbiter state encoding, the source-tag values and the counter step helper.
package axis_packet_merge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } merge_state_t;

  localparam logic TID_EVEN = 1'b0;
  localparam logic TID_ODD  = 1'b1;

  // Packet counters are free-running and wrap from all-ones back to zero.
  function automatic logic [31:0] count_inc(input logic [31:0] cnt);
    return cnt + 32'd1;
  endfunction

endpackage

// File: rtl/axis_packet_merge_if.sv
// AXI-Stream bundle shared by the merger inputs and output.
// tid is only meaningful on the merged output; inputs may leave it constant.
interface axis_packet_merge_if #(
  parameter int TDATA_WIDTH = 32
);

  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tlast;
  logic                   tid;
  logic                   tvalid;
  logic                   tready;

  modport master (
    output tdata,
    output tlast,
    output tid,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tlast,
    input  tid,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer: registers valid/payload and presents a registered ready upstream.
// Full throughput when the sink is always ready; one extra cycle of latency per beat.
module axis_skid_buffer #(
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  logic             skid_valid_q;
  logic             skid_valid_d;
  logic [WIDTH-1:0] skid_data_q;
  logic             push;
  logic             load_out;

  assign push     = s_valid & s_ready;
  assign load_out = m_ready | ~m_valid;

  always_comb begin
    skid_valid_d = skid_valid_q;
    if (load_out) begin
      skid_valid_d = 1'b0;
    end else if (push) begin
      skid_valid_d = 1'b1;
    end
  end

  // Output stage refills from the skid entry first so beat order is preserved.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      m_valid      <= 1'b0;
      m_data       <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      s_ready      <= 1'b0;
    end else begin
      if (load_out) begin
        if (skid_valid_q) begin
          m_valid <= 1'b1;
          m_data  <= skid_data_q;
        end else begin
          m_valid <= push;
          if (push) begin
            m_data <= s_data;
          end
        end
      end else if (push) begin
        skid_data_q <= s_data;
      end
      skid_valid_q <= skid_valid_d;
      s_ready      <= ~skid_valid_d;
    end
  end

endmodule

// File: rtl/axis_packet_merge.sv
// Packet-atomic round-robin merge of two AXI-Stream inputs onto one tagged output.
// Define AXIS_PACKET_MERGE_OUTPUT_REG_EN to register the output through a skid buffer.
//
// state | meaning
// IDLE  | no grant; arbitrate on the next sampled tvalid
// BUSY0 | s0 owns the output until its tlast handshake
// BUSY1 | s1 owns the output until its tlast handshake
module axis_packet_merge
  import axis_packet_merge_pkg::*;
#(
  parameter int TDATA_WIDTH = 32
) (
  input  logic                clk,
  input  logic                resetn,
  axis_packet_merge_if.slave  s0_axis,
  axis_packet_merge_if.slave  s1_axis,
  axis_packet_merge_if.master m_axis,
  output logic [31:0]         pkt_count0,
  output logic [31:0]         pkt_count1
);

  localparam int PW = TDATA_WIDTH + 2;

  merge_state_t           state_q;
  merge_state_t           state_d;
  logic                   last_grant_q;
  logic                   last_grant_d;
  logic                   grant_port;
  logic                   int_ready;
  logic                   sel_valid;
  logic                   sel_last;
  logic                   sel_tid;
  logic [TDATA_WIDTH-1:0] sel_data;
  logic                   eop0;
  logic                   eop1;

  assign eop0       = s0_axis.tvalid & s0_axis.tready & s0_axis.tlast;
  assign eop1       = s1_axis.tvalid & s1_axis.tready & s1_axis.tlast;
  assign grant_port = ~last_grant_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      last_grant_q <= TID_ODD;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // last_grant only moves on real contention; a lone requester does not steal priority.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (s0_axis.tvalid && s1_axis.tvalid) begin
          state_d      = (grant_port == TID_ODD) ? BUSY1 : BUSY0;
          last_grant_d = grant_port;
        end else if (s0_axis.tvalid) begin
          state_d = BUSY0;
        end else if (s1_axis.tvalid) begin
          state_d = BUSY1;
        end
      end
      BUSY0: begin
        if (eop0) begin
          state_d = IDLE;
        end
      end
      BUSY1: begin
        if (eop1) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    s0_axis.tready = 1'b0;
    s1_axis.tready = 1'b0;
    sel_valid      = 1'b0;
    sel_last       = 1'b0;
    sel_tid        = TID_EVEN;
    sel_data       = '0;
    case (state_q)
      BUSY0: begin
        s0_axis.tready = int_ready;
        sel_valid      = s0_axis.tvalid;
        sel_last       = s0_axis.tlast;
        sel_data       = s0_axis.tdata;
        sel_tid        = TID_EVEN;
      end
      BUSY1: begin
        s1_axis.tready = int_ready;
        sel_valid      = s1_axis.tvalid;
        sel_last       = s1_axis.tlast;
        sel_data       = s1_axis.tdata;
        sel_tid        = TID_ODD;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pkt_count0 <= '0;
      pkt_count1 <= '0;
    end else begin
      if (eop0) begin
        pkt_count0 <= count_inc(pkt_count0);
      end
      if (eop1) begin
        pkt_count1 <= count_inc(pkt_count1);
      end
    end
  end

`ifdef AXIS_PACKET_MERGE_OUTPUT_REG_EN
  logic [PW-1:0] skid_out;
  logic          skid_in_ready;

  axis_skid_buffer #(
    .WIDTH (PW)
  ) u_skid (
    .clk     (clk),
    .resetn  (resetn),
    .s_valid (sel_valid),
    .s_ready (skid_in_ready),
    .s_data  ({sel_tid, sel_last, sel_data}),
    .m_valid (m_axis.tvalid),
    .m_ready (m_axis.tready),
    .m_data  (skid_out)
  );

  assign int_ready     = skid_in_ready;
  assign m_axis.tid    = skid_out[PW-1];
  assign m_axis.tlast  = skid_out[PW-2];
  assign m_axis.tdata  = skid_out[TDATA_WIDTH-1:0];
`else
  assign int_ready     = m_axis.tready;
  assign m_axis.tvalid = sel_valid;
  assign m_axis.tid    = sel_tid;
  assign m_axis.tlast  = sel_last;
  assign m_axis.tdata  = sel_data;
`endif

endmodule
